stream_reorder_buf: RTL and testbench

- Parametrised successor to the single-lane `in`/`out`/`out_valid` test DUT.
- Collects a frame of DEPTH input words of WIDTH bits, each qualified by in_valid.
- Replays the frame on out with out_valid, in one of four orders selected per frame.
- Sits under the standard TESTBED/PATTERN harness as the DUT; reused as a building block in later labs.

---
 rtl/stream_reorder_buf.sv | 166 ++++++++++++++++
 tb/tb_stream_reorder_buf.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stream_reorder_buf.sv
// Frame reorder buffer: collects DEPTH words, replays them forward, reversed, ascending or descending.
// Optional STREAM_SUM_EN adds out_sum, the frame sum presented on the last output beat.
module stream_reorder_buf #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [WIDTH-1:0]                     in,
  input  logic [1:0]                           mode,
  output logic                                 out_valid,
  output logic [WIDTH-1:0]                     out,
`ifdef STREAM_SUM_EN
  output logic [WIDTH+$clog2(DEPTH)-1:0]       out_sum,
`endif
  output logic                                 busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = WIDTH + $clog2(DEPTH);

  localparam logic [1:0] MODE_FWD = 2'd0;
  localparam logic [1:0] MODE_REV = 2'd1;

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

  state_t            state;
  logic [WIDTH-1:0]  buf_q [DEPTH];
  logic [WIDTH-1:0]  view  [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        mode_q;
  logic [DEPTH-1:0]  used;

  logic              start;
  logic              last_beat;
  logic [IDX_W-1:0]  pos;
  logic              found;
  logic [IDX_W-1:0]  best_idx;
  logic [WIDTH-1:0]  best_val;
  logic [IDX_W-1:0]  sel_idx;
  logic [WIDTH-1:0]  sel_word;

  assign start     = (state == IDLE) && in_valid;
  assign last_beat = (state == COLLECT) && in_valid && (cnt == CNT_W'(DEPTH - 1));
  // First output word is chosen on the same edge that accepts the last beat.
  assign pos       = last_beat ? '0 : IDX_W'(cnt);

  // Buffer view with the incoming last beat bypassed into its slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view[i] = buf_q[i];
    end
    if (last_beat) begin
      view[DEPTH-1] = in;
    end
  end

  // Min/max scan over unused words; strict compares keep the lowest index on ties.
  always_comb begin
    found    = 1'b0;
    best_idx = '0;
    best_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!used[i] && (!found || (mode_q[0] ? (view[i] > best_val) : (view[i] < best_val)))) begin
        found    = 1'b1;
        best_idx = IDX_W'(i);
        best_val = view[i];
      end
    end
  end

  always_comb begin
    case (mode_q)
      MODE_FWD: sel_idx = pos;
      MODE_REV: sel_idx = IDX_W'(DEPTH - 1) - pos;
      default:  sel_idx = best_idx;
    endcase
    sel_word = view[sel_idx];
  end

  always_ff @(posedge clk) begin
    if (start) begin
      buf_q[0] <= in;
    end else if ((state == COLLECT) && in_valid) begin
      buf_q[IDX_W'(cnt)] <= in;
    end
  end

  // Control FSM; cnt counts accepted beats in COLLECT and emitted words in OUTPUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= '0;
      used      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out       <= '0;
          if (in_valid) begin
            mode_q <= mode;
            cnt    <= CNT_W'(1);
            used   <= '0;
            busy   <= 1'b1;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (last_beat) begin
            state         <= OUTPUT;
            cnt           <= CNT_W'(1);
            out_valid     <= 1'b1;
            out           <= sel_word;
            used[sel_idx] <= 1'b1;
          end else if (in_valid) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OUTPUT: begin
          if (cnt == CNT_W'(DEPTH)) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            busy      <= 1'b0;
          end else begin
            out           <= sel_word;
            used[sel_idx] <= 1'b1;
            cnt           <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STREAM_SUM_EN
  logic [SUM_W-1:0] acc;

  // Frame accumulator; sum is exposed only alongside the final output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      out_sum <= '0;
    end else begin
      if (start) begin
        acc <= SUM_W'(in);
      end else if ((state == COLLECT) && in_valid) begin
        acc <= acc + SUM_W'(in);
      end
      if ((state == OUTPUT) && (cnt == CNT_W'(DEPTH - 1))) begin
        out_sum <= acc;
      end else begin
        out_sum <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_reorder_buf.sv
// Randomized self-checking bench for stream_reorder_buf against a sorting reference model.
module tb_stream_reorder_buf;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SUM_W = WIDTH + $clog2(DEPTH);

  typedef logic [WIDTH-1:0] frame_t [DEPTH];
  typedef int gap_t [DEPTH];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_w;
  logic [1:0]       mode;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             busy;
`ifdef STREAM_SUM_EN
  logic [SUM_W-1:0] out_sum;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stream_reorder_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in_w),
    .mode      (mode),
    .out_valid (out_valid),
    .out       (out),
`ifdef STREAM_SUM_EN
    .out_sum   (out_sum),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference order: plain copy, reversed copy, or a stable counting sort by value.
  function automatic frame_t model_order(input frame_t d, input logic [1:0] m);
    frame_t r;
    int k;
    k = 0;
    r = d;
    case (m)
      2'd0: r = d;
      2'd1: for (int i = 0; i < DEPTH; i++) r[i] = d[DEPTH-1-i];
      2'd2: for (int v = 0; v < (1 << WIDTH); v++)
              for (int i = 0; i < DEPTH; i++)
                if (d[i] == WIDTH'(v)) begin r[k] = d[i]; k++; end
      default: for (int v = (1 << WIDTH) - 1; v >= 0; v--)
              for (int i = 0; i < DEPTH; i++)
                if (d[i] == WIDTH'(v)) begin r[k] = d[i]; k++; end
    endcase
    return r;
  endfunction

  task automatic idle_check(input string tag);
    check({tag, "_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef STREAM_SUM_EN
    check({tag, "_sum"}, 32'(out_sum), 32'd0);
`endif
  endtask

  // Drives one frame starting at a negedge and checks every output cycle; abort_after<DEPTH resets mid-output.
  task automatic run_frame(input frame_t d, input logic [1:0] m, input gap_t gaps,
                           input bit hold, input int abort_after);
    frame_t e;
    logic [SUM_W-1:0] s;
    e = model_order(d, m);
    s = '0;
    for (int i = 0; i < DEPTH; i++) s += SUM_W'(d[i]);
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_w     = d[i];
      mode     = (i == 0) ? m : 2'($urandom);
      @(negedge clk);
      if (i < DEPTH - 1) begin
        check("busy_collect", 32'(busy), 32'd1);
        check("ov_collect", 32'(out_valid), 32'd0);
        for (int g = 0; g < gaps[i]; g++) begin
          in_valid = 1'b0;
          in_w     = WIDTH'($urandom);
          mode     = 2'($urandom);
          @(negedge clk);
          check("busy_gap", 32'(busy), 32'd1);
          check("ov_gap", 32'(out_valid), 32'd0);
        end
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (j == abort_after) begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        idle_check("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          idle_check("post_abort");
        end
        return;
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("out", 32'(out), 32'(e[j]));
      check("busy_out", 32'(busy), 32'd1);
`ifdef STREAM_SUM_EN
      check("out_sum", 32'(out_sum), (j == DEPTH - 1) ? 32'(s) : 32'd0);
`endif
      in_valid = hold;
      in_w     = WIDTH'($urandom);
      mode     = 2'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    idle_check("end");
  endtask

  initial begin
    frame_t d;
    gap_t   gz;
    gap_t   gp;
    bit     hold;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_w     = '0;
    mode     = '0;
    for (int i = 0; i < DEPTH; i++) begin gz[i] = 0; gp[i] = 0; end
    #1;
    idle_check("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      idle_check("idle");
    end

    for (int i = 0; i < DEPTH; i++) d[i] = WIDTH'(i + 1);
    run_frame(d, 2'd0, gz, 1'b0, DEPTH);
    gp[2] = 2;
    gp[4] = 2;
    run_frame(d, 2'd1, gp, 1'b0, DEPTH);

    d[0] = 4'h5; d[1] = 4'h3; d[2] = 4'h9; d[3] = 4'h3;
    d[4] = 4'h0; d[5] = 4'hF; d[6] = 4'h1; d[7] = 4'h5;
    run_frame(d, 2'd2, gz, 1'b0, DEPTH);
    run_frame(d, 2'd3, gz, 1'b0, DEPTH);

    run_frame(d, 2'd0, gz, 1'b0, 3);
    for (int i = 0; i < DEPTH; i++) d[i] = 4'hA;
    run_frame(d, 2'd0, gz, 1'b0, DEPTH);

    for (int i = 0; i < DEPTH; i++) d[i] = WIDTH'(3 * i + 2);
    run_frame(d, 2'd1, gz, 1'b1, DEPTH);
    run_frame(d, 2'd2, gz, 1'b1, DEPTH);

    for (int f = 0; f < 30; f++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < DEPTH; i++) begin
        d[i]  = narrow ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
        gp[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      hold = ($urandom_range(0, 1) == 1);
      run_frame(d, 2'($urandom), gp, hold, (f % 10 == 9) ? int'($urandom_range(0, DEPTH - 1)) : DEPTH);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        idle_check("between");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
